// File: rtl/adc_trigger_ctrl.sv
// Capture sequencer ahead of the ADC sample FIFO: arms, qualifies a trigger,
// waits a programmable offset, then holds capture_go until the FIFO stops it.
module adc_trigger_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             adc_sampleclk,
    input  logic             reset_i,
    input  logic             arm_i,
    input  logic             trig_in,
    input  logic [1:0]       trig_mode_i,
    input  logic [CNT_W-1:0] trig_offset_i,
    input  logic [CNT_W-1:0] timeout_i,
    input  logic             capture_stop_i,
    output logic             capture_go_o,
    output logic             armed_o,
    output logic             trig_status_o,
    output logic             trig_now_o,
    output logic             triggered_o,
    output logic             timed_out_o,
    output logic             capture_done_o,
    output logic [CNT_W-1:0] trig_latency_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        DELAY   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_r;
    logic             arm_prev_r;
    logic             trig_prev_r;
    logic [CNT_W-1:0] off_cnt_r;
    logic [CNT_W-1:0] tmo_cnt_r;
    logic             tc_s;
    logic             arm_edge_s;
    logic             tmo_hit_s;

    // Mode-qualified trigger condition
    always_comb begin
        tc_s = 1'b0;
        case (trig_mode_i)
            2'b00:   tc_s = trig_in & ~trig_prev_r;
            2'b01:   tc_s = ~trig_in & trig_prev_r;
            2'b10:   tc_s = trig_in;
            2'b11:   tc_s = ~trig_in;
            default: tc_s = 1'b0;
        endcase
    end

    // Arm edge and timeout match; a zero timeout disables the forced trigger
    always_comb begin
        arm_edge_s = arm_i & ~arm_prev_r;
        if (timeout_i != CNT_ZERO) begin
            tmo_hit_s = (tmo_cnt_r == timeout_i);
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Sequencer state, counters and registered outputs
    always_ff @(posedge adc_sampleclk or posedge reset_i) begin
        if (reset_i) begin
            state_r        <= IDLE;
            arm_prev_r     <= 1'b0;
            trig_prev_r    <= 1'b0;
            off_cnt_r      <= CNT_ZERO;
            tmo_cnt_r      <= CNT_ZERO;
            capture_go_o   <= 1'b0;
            armed_o        <= 1'b0;
            trig_status_o  <= 1'b0;
            trig_now_o     <= 1'b0;
            triggered_o    <= 1'b0;
            timed_out_o    <= 1'b0;
            capture_done_o <= 1'b0;
            trig_latency_o <= CNT_ZERO;
        end else begin
            arm_prev_r    <= arm_i;
            trig_prev_r   <= trig_in;
            trig_status_o <= tc_s;
            trig_now_o    <= 1'b0;
            if (arm_edge_s) begin
                state_r        <= ARMED;
                triggered_o    <= 1'b0;
                timed_out_o    <= 1'b0;
                trig_latency_o <= CNT_ZERO;
                tmo_cnt_r      <= CNT_ZERO;
                armed_o        <= 1'b1;
                capture_go_o   <= 1'b0;
                capture_done_o <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        armed_o        <= 1'b0;
                        capture_go_o   <= 1'b0;
                        capture_done_o <= 1'b0;
                    end
                    ARMED: begin
                        if (!arm_i) begin
                            state_r <= IDLE;
                            armed_o <= 1'b0;
                        end else if (tc_s || tmo_hit_s) begin
                            // A real trigger takes precedence over a coincident timeout
                            trig_now_o  <= 1'b1;
                            triggered_o <= 1'b1;
                            timed_out_o <= ~tc_s;
                            if (trig_offset_i == CNT_ZERO) begin
                                state_r      <= CAPTURE;
                                armed_o      <= 1'b0;
                                capture_go_o <= 1'b1;
                            end else begin
                                state_r   <= DELAY;
                                off_cnt_r <= trig_offset_i;
                            end
                        end else begin
                            if (trig_latency_o != CNT_MAX) begin
                                trig_latency_o <= trig_latency_o + CNT_ONE;
                            end
                            if (tmo_cnt_r != CNT_MAX) begin
                                tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
                            end
                        end
                    end
                    DELAY: begin
                        if (!arm_i) begin
                            state_r <= IDLE;
                            armed_o <= 1'b0;
                        end else if (off_cnt_r == CNT_ONE) begin
                            state_r      <= CAPTURE;
                            armed_o      <= 1'b0;
                            capture_go_o <= 1'b1;
                        end else begin
                            off_cnt_r <= off_cnt_r - CNT_ONE;
                        end
                    end
                    CAPTURE: begin
                        if (capture_stop_i) begin
                            state_r        <= DONE;
                            capture_go_o   <= 1'b0;
                            capture_done_o <= 1'b1;
                        end
                    end
                    DONE: begin
                        capture_done_o <= 1'b1;
                    end
                    default: begin
                        state_r        <= IDLE;
                        armed_o        <= 1'b0;
                        capture_go_o   <= 1'b0;
                        capture_done_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
